// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one memory port among NUM_PORTS requesters
// Optional alignment checking is enabled by defining MEM_ARB_MISALIGN_CHECK_EN.
module mem_port_arbiter #(
    parameter int NUM_PORTS   = 2,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 64,
    parameter int MEM_LATENCY = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS-1:0]            req_valid,
    output logic [NUM_PORTS-1:0]            req_ready,
    input  logic [NUM_PORTS-1:0]            req_we,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_wdata,
    input  logic [NUM_PORTS*3-1:0]          req_width,
    output logic [NUM_PORTS-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]           rsp_rdata,
    output logic                            rsp_error,
    output logic                            mem_read_en,
    output logic                            mem_write_en,
    output logic [ADDR_WIDTH-1:0]           mem_addr,
    output logic [DATA_WIDTH-1:0]           mem_write_data,
    output logic [2:0]                      mem_width,
    input  logic [DATA_WIDTH-1:0]           mem_data_fetched,
    output logic                            busy
);

    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [NUM_PORTS-1:0] ONE = NUM_PORTS'(1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                 state;
    logic [IDX_W-1:0]       last_grant;
    logic [IDX_W-1:0]       grant_idx;
    logic                   grant_found;
    logic                   we_q;
    logic [CNT_W-1:0]       count;
    logic [ADDR_WIDTH-1:0]  sel_addr;
    logic [DATA_WIDTH-1:0]  sel_wdata;
    logic [2:0]             sel_width;
    logic                   sel_we;

    // Cyclic search starting just after the previous winner.
    always_comb begin
        int idx;
        idx         = 0;
        grant_idx   = last_grant;
        grant_found = 1'b0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            idx = int'(last_grant) + k;
            if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
            if (!grant_found && req_valid[IDX_W'(idx)]) begin
                grant_found = 1'b1;
                grant_idx   = IDX_W'(idx);
            end
        end
    end

    assign sel_addr  = req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign sel_wdata = req_wdata[grant_idx*DATA_WIDTH +: DATA_WIDTH];
    assign sel_width = req_width[grant_idx*3 +: 3];
    assign sel_we    = req_we[grant_idx];

    assign req_ready = (state == IDLE && !rst && grant_found) ? (ONE << grant_idx) : '0;

`ifdef MEM_ARB_MISALIGN_CHECK_EN
    function automatic logic misaligned(input logic [2:0] width, input logic [2:0] addr);
        case (width[1:0])
            2'b01:   misaligned = addr[0];
            2'b10:   misaligned = |addr[1:0];
            2'b11:   misaligned = |addr[2:0];
            default: misaligned = 1'b0;
        endcase
    endfunction
`else
    assign rsp_error = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            last_grant     <= IDX_W'(NUM_PORTS - 1);
            we_q           <= 1'b0;
            count          <= '0;
            rsp_valid      <= '0;
            rsp_rdata      <= '0;
            mem_read_en    <= 1'b0;
            mem_write_en   <= 1'b0;
            mem_addr       <= '0;
            mem_write_data <= '0;
            mem_width      <= 3'b000;
            busy           <= 1'b0;
`ifdef MEM_ARB_MISALIGN_CHECK_EN
            rsp_error      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        last_grant     <= grant_idx;
                        busy           <= 1'b1;
                        we_q           <= sel_we;
                        mem_addr       <= sel_addr;
                        mem_write_data <= sel_wdata;
                        mem_width      <= sel_width;
`ifdef MEM_ARB_MISALIGN_CHECK_EN
                        if (misaligned(sel_width, sel_addr[2:0])) begin
                            state     <= RESP;
                            rsp_valid <= ONE << grant_idx;
                            rsp_rdata <= '0;
                            rsp_error <= 1'b1;
                        end else
`endif
                        begin
                            state        <= ISSUE;
                            mem_write_en <= sel_we;
                            mem_read_en  <= !sel_we;
                        end
                    end
                end
                ISSUE: begin
                    mem_write_en <= 1'b0;
                    mem_read_en  <= 1'b0;
                    if (we_q) begin
                        state     <= RESP;
                        rsp_rdata <= '0;
                        rsp_valid <= ONE << last_grant;
                    end else begin
                        state <= WAIT;
                        count <= CNT_W'(MEM_LATENCY - 1);
                    end
                end
                WAIT: begin
                    if (count == '0) begin
                        state     <= RESP;
                        rsp_rdata <= mem_data_fetched;
                        rsp_valid <= ONE << last_grant;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    rsp_valid <= '0;
                    busy      <= 1'b0;
`ifdef MEM_ARB_MISALIGN_CHECK_EN
                    rsp_error <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    localparam logic [63:0] GARBAGE = 64'hBADBADBADBADBAD0;
    localparam logic [63:0] RD1     = 64'h1122334455667788;
    localparam logic [63:0] RD3     = 64'hCAFEF00D12345678;

    logic         clk = 1'b0;
    logic         rst = 1'b1;

    logic [1:0]   req_valid = '0, req_ready, req_we = '0, rsp_valid;
    logic [63:0]  req_addr = '0;
    logic [127:0] req_wdata = '0;
    logic [5:0]   req_width = '0;
    logic [63:0]  rsp_rdata, mem_write_data, mem_data_fetched;
    logic         rsp_error, mem_read_en, mem_write_en, busy;
    logic [31:0]  mem_addr;
    logic [2:0]   mem_width;

    logic [1:0]   req3_valid = '0, req3_ready, req3_we = '0, rsp3_valid;
    logic [63:0]  req3_addr = '0;
    logic [127:0] req3_wdata = '0;
    logic [5:0]   req3_width = '0;
    logic [63:0]  rsp3_rdata, mem3_write_data, mem3_data_fetched;
    logic         rsp3_error, mem3_read_en, mem3_write_en, busy3;
    logic [31:0]  mem3_addr;
    logic [2:0]   mem3_width;

    logic         sh1 = 1'b0;
    logic [2:0]   sh3 = '0;
    int           pass_cnt = 0;
    int           total_cnt = 0;

    always #5 clk = ~clk;

    // Memory models return valid data only in the exact latency cycle.
    always @(posedge clk) begin
        sh1 <= mem_read_en;
        sh3 <= {sh3[1:0], mem3_read_en};
    end
    assign mem_data_fetched  = sh1 ? RD1 : GARBAGE;
    assign mem3_data_fetched = sh3[2] ? RD3 : GARBAGE;

    mem_port_arbiter #(.NUM_PORTS(2), .ADDR_WIDTH(32), .DATA_WIDTH(64), .MEM_LATENCY(1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_width(req_width),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .mem_read_en(mem_read_en), .mem_write_en(mem_write_en), .mem_addr(mem_addr),
        .mem_write_data(mem_write_data), .mem_width(mem_width),
        .mem_data_fetched(mem_data_fetched), .busy(busy)
    );

    mem_port_arbiter #(.NUM_PORTS(2), .ADDR_WIDTH(32), .DATA_WIDTH(64), .MEM_LATENCY(3)) dut3 (
        .clk(clk), .rst(rst), .req_valid(req3_valid), .req_ready(req3_ready), .req_we(req3_we),
        .req_addr(req3_addr), .req_wdata(req3_wdata), .req_width(req3_width),
        .rsp_valid(rsp3_valid), .rsp_rdata(rsp3_rdata), .rsp_error(rsp3_error),
        .mem_read_en(mem3_read_en), .mem_write_en(mem3_write_en), .mem_addr(mem3_addr),
        .mem_write_data(mem3_write_data), .mem_width(mem3_width),
        .mem_data_fetched(mem3_data_fetched), .busy(busy3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input logic we, input logic [31:0] addr,
                           input logic [63:0] wdata, input logic [2:0] width);
        req_we[p]             = we;
        req_addr[p*32 +: 32]  = addr;
        req_wdata[p*64 +: 64] = wdata;
        req_width[p*3 +: 3]   = width;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 2'b11;
        tick();
        tick();
        #1;
        total_cnt++; if (req_ready !== 2'b00) $display("FAIL reset_ready got=%b exp=00", req_ready); else pass_cnt++;
        total_cnt++; if (rsp_valid !== 2'b00) $display("FAIL reset_rsp_valid got=%b exp=00", rsp_valid); else pass_cnt++;
        total_cnt++; if (rsp_rdata !== 64'h0) $display("FAIL reset_rdata got=%h exp=0", rsp_rdata); else pass_cnt++;
        total_cnt++; if ({mem_read_en, mem_write_en, busy, rsp_error} !== 4'b0000)
            $display("FAIL reset_strobes got=%b exp=0000", {mem_read_en, mem_write_en, busy, rsp_error}); else pass_cnt++;
        total_cnt++; if (mem_addr !== 32'h0 || mem_width !== 3'b000)
            $display("FAIL reset_mem_addr got=%h/%b exp=0/000", mem_addr, mem_width); else pass_cnt++;
        req_valid = 2'b00;
        rst = 1'b0;
        tick();
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy_after got=%b exp=0", busy); else pass_cnt++;
    endtask

    task automatic test_read();
        set_req(0, 1'b0, 32'h10, 64'h0, 3'b011);
        req_valid = 2'b01;
        #1;
        total_cnt++; if (req_ready !== 2'b01) $display("FAIL read_ready got=%b exp=01", req_ready); else pass_cnt++;
        tick();
        req_valid = 2'b00;
        total_cnt++; if (mem_read_en !== 1'b1 || mem_write_en !== 1'b0 || mem_addr !== 32'h10)
            $display("FAIL read_issue got=re%b we%b addr=%h exp=re1 we0 addr=10", mem_read_en, mem_write_en, mem_addr); else pass_cnt++;
        total_cnt++; if (busy !== 1'b1) $display("FAIL read_busy got=%b exp=1", busy); else pass_cnt++;
        tick();
        total_cnt++; if (mem_read_en !== 1'b0 || rsp_valid !== 2'b00)
            $display("FAIL read_wait got=re%b rsp=%b exp=re0 rsp=00", mem_read_en, rsp_valid); else pass_cnt++;
        tick();
        total_cnt++; if (rsp_valid !== 2'b01) $display("FAIL read_rsp_valid got=%b exp=01", rsp_valid); else pass_cnt++;
        total_cnt++; if (rsp_rdata !== RD1) $display("FAIL read_rdata got=%h exp=%h", rsp_rdata, RD1); else pass_cnt++;
        tick();
        total_cnt++; if (rsp_valid !== 2'b00 || busy !== 1'b0 || rsp_rdata !== RD1)
            $display("FAIL read_after got=rsp%b busy%b data=%h exp=rsp00 busy0 data=%h", rsp_valid, busy, rsp_rdata, RD1); else pass_cnt++;
    endtask

    task automatic test_write();
        logic saw_read;
        saw_read = 1'b0;
        set_req(1, 1'b1, 32'h20, 64'hDEADBEEF, 3'b010);
        req_valid = 2'b10;
        #1;
        total_cnt++; if (req_ready !== 2'b10) $display("FAIL write_ready got=%b exp=10", req_ready); else pass_cnt++;
        tick();
        req_valid = 2'b00;
        saw_read = saw_read | mem_read_en;
        total_cnt++; if (mem_write_en !== 1'b1 || mem_addr !== 32'h20 || mem_write_data !== 64'hDEADBEEF || mem_width !== 3'b010)
            $display("FAIL write_issue got=we%b addr=%h data=%h w=%b exp=we1 addr=20 data=deadbeef w=010",
                     mem_write_en, mem_addr, mem_write_data, mem_width); else pass_cnt++;
        tick();
        saw_read = saw_read | mem_read_en;
        total_cnt++; if (rsp_valid !== 2'b10 || mem_write_en !== 1'b0)
            $display("FAIL write_rsp got=rsp%b we%b exp=rsp10 we0", rsp_valid, mem_write_en); else pass_cnt++;
        total_cnt++; if (rsp_rdata !== 64'h0) $display("FAIL write_rdata got=%h exp=0", rsp_rdata); else pass_cnt++;
        tick();
        saw_read = saw_read | mem_read_en;
        total_cnt++; if (saw_read !== 1'b0) $display("FAIL write_no_read got=%b exp=0", saw_read); else pass_cnt++;
    endtask

    task automatic test_round_robin();
        logic [1:0] exp;
        do_reset();
        set_req(0, 1'b1, 32'h100, 64'h1, 3'b011);
        set_req(1, 1'b1, 32'h200, 64'h2, 3'b011);
        req_valid = 2'b11;
        #1;
        for (int t = 0; t < 4; t++) begin
            exp = (t % 2 == 0) ? 2'b01 : 2'b10;
            for (int c = 0; c < 10 && req_ready == 2'b00; c++) tick();
            total_cnt++; if (req_ready !== exp) $display("FAIL rr_grant%0d got=%b exp=%b", t, req_ready, exp); else pass_cnt++;
            tick();
            tick();
            total_cnt++; if (rsp_valid !== exp) $display("FAIL rr_rsp%0d got=%b exp=%b", t, rsp_valid, exp); else pass_cnt++;
            tick();
        end
        req_valid = 2'b00;
        tick();
    endtask

    task automatic test_latency3();
        do_reset();
        req3_we = 2'b00;
        req3_addr[31:0] = 32'h40;
        req3_width[2:0] = 3'b011;
        req3_valid = 2'b01;
        #1;
        total_cnt++; if (req3_ready !== 2'b01) $display("FAIL lat3_ready got=%b exp=01", req3_ready); else pass_cnt++;
        tick();
        req3_valid = 2'b00;
        total_cnt++; if (mem3_read_en !== 1'b1 || mem3_addr !== 32'h40)
            $display("FAIL lat3_issue got=re%b addr=%h exp=re1 addr=40", mem3_read_en, mem3_addr); else pass_cnt++;
        for (int c = 2; c <= 4; c++) begin
            tick();
            total_cnt++; if (rsp3_valid !== 2'b00 || mem3_read_en !== 1'b0 || busy3 !== 1'b1)
                $display("FAIL lat3_wait%0d got=rsp%b re%b busy%b exp=rsp00 re0 busy1", c, rsp3_valid, mem3_read_en, busy3); else pass_cnt++;
        end
        tick();
        total_cnt++; if (rsp3_valid !== 2'b01 || rsp3_rdata !== RD3)
            $display("FAIL lat3_rsp got=rsp%b data=%h exp=rsp01 data=%h", rsp3_valid, rsp3_rdata, RD3); else pass_cnt++;
        tick();
    endtask

    task automatic test_mid_reset();
        logic [1:0] rsp_seen;
        rsp_seen = 2'b00;
        set_req(0, 1'b0, 32'h30, 64'h0, 3'b011);
        req_valid = 2'b01;
        #1;
        tick();
        req_valid = 2'b00;
        tick();
        rst = 1'b1;
        tick();
        rsp_seen = rsp_seen | rsp_valid;
        total_cnt++; if (busy !== 1'b0 || mem_read_en !== 1'b0)
            $display("FAIL midrst_busy got=busy%b re%b exp=busy0 re0", busy, mem_read_en); else pass_cnt++;
        rst = 1'b0;
        set_req(1, 1'b0, 32'h38, 64'h0, 3'b011);
        req_valid = 2'b11;
        #1;
        total_cnt++; if (req_ready !== 2'b01) $display("FAIL midrst_next_grant got=%b exp=01", req_ready); else pass_cnt++;
        req_valid = 2'b00;
        tick();
        rsp_seen = rsp_seen | rsp_valid;
        tick();
        rsp_seen = rsp_seen | rsp_valid;
        total_cnt++; if (rsp_seen !== 2'b00 || busy !== 1'b0)
            $display("FAIL midrst_no_rsp got=rsp%b busy%b exp=rsp00 busy0", rsp_seen, busy); else pass_cnt++;
    endtask

    task automatic test_misalign();
        set_req(0, 1'b0, 32'h102, 64'h0, 3'b010);
        req_valid = 2'b01;
        #1;
        tick();
        req_valid = 2'b00;
`ifdef MEM_ARB_MISALIGN_CHECK_EN
        total_cnt++; if (mem_read_en !== 1'b0 || mem_write_en !== 1'b0)
            $display("FAIL misalign_strobe got=re%b we%b exp=re0 we0", mem_read_en, mem_write_en); else pass_cnt++;
        total_cnt++; if (rsp_valid !== 2'b01 || rsp_error !== 1'b1 || rsp_rdata !== 64'h0)
            $display("FAIL misalign_rsp got=rsp%b err%b data=%h exp=rsp01 err1 data=0", rsp_valid, rsp_error, rsp_rdata); else pass_cnt++;
        tick();
`else
        total_cnt++; if (mem_read_en !== 1'b1 || mem_addr !== 32'h102)
            $display("FAIL misalign_issue got=re%b addr=%h exp=re1 addr=102", mem_read_en, mem_addr); else pass_cnt++;
        tick();
        tick();
        total_cnt++; if (rsp_valid !== 2'b01 || rsp_error !== 1'b0 || rsp_rdata !== RD1)
            $display("FAIL misalign_rsp got=rsp%b err%b data=%h exp=rsp01 err0 data=%h", rsp_valid, rsp_error, rsp_rdata, RD1); else pass_cnt++;
        tick();
`endif
        total_cnt++; if (rsp_valid !== 2'b00 || busy !== 1'b0)
            $display("FAIL misalign_after got=rsp%b busy%b exp=rsp00 busy0", rsp_valid, busy); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_round_robin();
        test_latency3();
        test_mid_reset();
        test_misalign();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
